// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
package pipeline_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU for the execute stage.
module alu
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [3:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult
);

  logic [4:0] shamt;

  assign shamt = SrcB[4:0];

  always_comb begin
    ALUResult = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD:   ALUResult = SrcA + SrcB;
      ALU_SUB:   ALUResult = SrcA - SrcB;
      ALU_SLL:   ALUResult = SrcA << shamt;
      ALU_SLT:   ALUResult[0] = $signed(SrcA) < $signed(SrcB);
      ALU_SLTU:  ALUResult[0] = SrcA < SrcB;
      ALU_XOR:   ALUResult = SrcA ^ SrcB;
      ALU_SRL:   ALUResult = SrcA >> shamt;
      ALU_SRA:   ALUResult = $unsigned($signed(SrcA) >>> shamt);
      ALU_OR:    ALUResult = SrcA | SrcB;
      ALU_AND:   ALUResult = SrcA & SrcB;
      ALU_PASSB: ALUResult = SrcB;
      default:   ALUResult = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register with stall (hold) and flush (bubble).
module execute_cycle
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            insn_vldE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [2:0]      funct3E,
  input  logic [4:0]      RD_ADDR_E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            insn_vldM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RD_ADDR_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            insn_vld;
    logic [1:0]      result_src;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] alu_result;
  } exmem_t;

  exmem_t          exmem_q, exmem_d;
  logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_result, jalr_sum;
  logic            taken;

  always_comb begin
    fwd_a = RD1_E;
    case (fwd_sel_e'(ForwardAE))
      FWD_WB:  fwd_a = ResultW;
      FWD_MEM: fwd_a = exmem_q.alu_result;
      default: fwd_a = RD1_E;
    endcase
    fwd_b = RD2_E;
    case (fwd_sel_e'(ForwardBE))
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = exmem_q.alu_result;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (fwd_a),
    .SrcB       (src_b),
    .ALUControl (ALUControlE),
    .ALUResult  (alu_result)
  );

  // Branches compare the register operands, never the immediate-muxed SrcB.
  always_comb begin
    taken = 1'b0;
    case (funct3E)
      F3_BEQ:  taken = (fwd_a == fwd_b);
      F3_BNE:  taken = (fwd_a != fwd_b);
      F3_BLT:  taken = ($signed(fwd_a) < $signed(fwd_b));
      F3_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: taken = (fwd_a < fwd_b);
      F3_BGEU: taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum  = fwd_a + Imm_Ext_E;
  assign PCSrcE    = insn_vldE & (JumpE | (BranchE & taken));
  assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + Imm_Ext_E);

  // Flush only needs to kill the control bits; data fields load as usual.
  always_comb begin
    exmem_d = exmem_q;
    if (i_flush || !i_stall) begin
      exmem_d.reg_write  = RegWriteE;
      exmem_d.mem_write  = MemWriteE;
      exmem_d.insn_vld   = insn_vldE;
      exmem_d.result_src = ResultSrcE;
      exmem_d.rd_addr    = RD_ADDR_E;
      exmem_d.pc_plus4   = PCPlus4E;
      exmem_d.write_data = fwd_b;
      exmem_d.alu_result = alu_result;
    end
    if (i_flush) begin
      exmem_d.reg_write  = 1'b0;
      exmem_d.mem_write  = 1'b0;
      exmem_d.insn_vld   = 1'b0;
      exmem_d.result_src = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) exmem_q <= '0;
    else          exmem_q <= exmem_d;
  end

  assign RegWriteM   = exmem_q.reg_write;
  assign MemWriteM   = exmem_q.mem_write;
  assign insn_vldM   = exmem_q.insn_vld;
  assign ResultSrcM  = exmem_q.result_src;
  assign RD_ADDR_M   = exmem_q.rd_addr;
  assign PCPlus4M    = exmem_q.pc_plus4;
  assign WriteDataM  = exmem_q.write_data;
  assign ALU_ResultM = exmem_q.alu_result;

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline; sits directly upstream of the memory stage and drives its M-suffixed inputs.
- Selects operands through forwarding muxes and computes the ALU result.
- Resolves branches and jumps: PCSrcE and PCTargetE go combinationally to fetch.
- Registers everything the memory stage consumes in the EX/MEM pipeline register, which supports stall (hold) and flush (bubble).

Parameters:
- XLEN, 32, datapath width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold EX/MEM register contents
- i_flush  in  1  load a bubble into EX/MEM
- RegWriteE, MemWriteE, insn_vldE  in  1 each  decoded control
- BranchE, JumpE, JalrE, ALUSrcE  in  1 each  decoded control; ALUSrcE=1 selects immediate
- ResultSrcE  in  2  writeback select, passed through
- ALUControlE  in  4  ALU operation code
- funct3E  in  3  branch condition
- RD_ADDR_E  in  5  destination register
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  XLEN each  operands and PCs
- ForwardAE, ForwardBE  in  2 each  forwarding select from the hazard unit
- ResultW  in  XLEN  writeback-stage result, forwarding source
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  redirect address (combinational)
- RegWriteM, MemWriteM, insn_vldM  out  1 each  registered
- ResultSrcM  out  2  registered
- RD_ADDR_M  out  5  registered
- PCPlus4M, WriteDataM, ALU_ResultM  out  XLEN each  registered

Behaviour:
- Reset (async, i_rst_n=0): all registered outputs clear to 0 immediately and stay 0 until the first rising edge after deassertion.
- Forwarding select, per operand:
  - 00: RD1_E / RD2_E
  - 01: ResultW
  - 10: current ALU_ResultM register value (the block's own output)
  - 11: treated as 00
- Operands:
  - SrcA = forwarded A.
  - SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
  - WriteData = forwarded B, always.
- ALU codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU
  - 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI)
  - 11-15 produce 0.
  - Shift amount is SrcB[4:0]; add/sub wrap modulo 2^XLEN; SLT/SLTU yield 0 or 1 zero-extended.
- Branch condition on forwarded A vs forwarded B (never on SrcB):
  - funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010/011: not taken.
- PCSrcE = insn_vldE & (JumpE | (BranchE & taken)).
- PCTargetE:
  - JalrE=1: (SrcA + Imm_Ext_E) with bit 0 cleared.
  - JalrE=0: PCE + Imm_Ext_E.
- EX/MEM register, evaluated at each rising edge, priority i_flush > i_stall > load:
  - flush: RegWriteM, MemWriteM, insn_vldM and ResultSrcM go to 0; data fields may take any value.
  - stall: all fields hold.
  - load: all fields capture the E-stage values or the computed results.
- Latency: E inputs appear on M outputs one cycle later.
- Simultaneous i_flush and i_stall: flush wins.
- insn_vldE=0: PCSrcE=0, and the register still loads normally.
- Reset mid-stall: register clears; the hold resumes from zero state.

Decomposition:
- Package pipeline_pkg holds:
  - alu_op_e enum (4-bit codes above)
  - fwd_sel_e enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10)
  - branch funct3 localparams
  - XLEN default
- Sub-module alu: combinational; SrcA, SrcB, ALUControl in; result out.
- Branch compare, target adder and the EX/MEM register stay in execute_cycle.

Test Plan:
- Reset with inputs non-zero (RD1_E=5, RegWriteE=1) held low for 3 cycles -> all M outputs 0; after release, next edge gives ALU_ResultM=RD1_E+RD2_E for ADD.
- ALU sweep with SrcA=0x8000_0000, SrcB=1:
  - SUB -> 0x7FFF_FFFF
  - SLT -> 1, SLTU -> 0
  - SRA -> 0xC000_0000, SRL -> 0x4000_0000
  - code 12 -> 0.
- Forwarding with RD1_E=1, ResultW=2, ALU_ResultM=3, ADD, ALUSrcE=1, Imm=0x10:
  - ForwardAE=10 -> next ALU_ResultM=0x13.
  - ForwardAE=01 -> 0x12.
  - ForwardBE=01 with ALUSrcE=1 -> WriteDataM=2.
- Branch BLT with funct3=100, BranchE=1, PCE=0x100, Imm=-8, A=-1, B=0:
  - -> PCSrcE=1, PCTargetE=0xF8.
  - Same with BLTU -> PCSrcE=0.
  - insn_vldE=0 -> PCSrcE=0.
- JALR with SrcA=0x1001, Imm=2 -> PCTargetE=0x1002, PCSrcE=1.
- Stall then flush:
  - Load a store with MemWriteM=1, then stall 2 cycles -> outputs unchanged.
  - Assert i_flush and i_stall together -> MemWriteM=0, RegWriteM=0, insn_vldM=0 next cycle.
